// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N stream demultiplexer with valid/ready on
// every port. Each output channel owns a one-entry register. Beats are routed
// either by in_sel (mode 0) or by a round-robin pointer (mode 1). A mode-0
// select beyond the last channel is consumed, discarded and counted.

module stream_demux_n #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]       rr_ptr,
    output logic [CNT_W-1:0]       drop_cnt
);

    // One extra bit so an out-of-range select compares correctly against N_OUT.
    localparam logic [SEL_W:0]   N_OUT_W = (SEL_W+1)'(N_OUT);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_OUT - 1);

    logic [N_OUT-1:0]       out_valid_q, out_valid_d;
    logic [N_OUT*WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]       drop_cnt_q,  drop_cnt_d;

    logic [SEL_W-1:0] dest;
    logic             dest_ok;
    logic             tgt_free;
    logic             wr_en;
    logic             drop_en;

    // Pick the destination and decide whether the input can be taken this cycle;
    // in_ready deliberately ignores in_valid.
    always_comb begin
        dest     = mode ? rr_ptr_q : in_sel;
        dest_ok  = ({1'b0, dest} < N_OUT_W);
        tgt_free = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (dest == SEL_W'(k)) begin
                tgt_free = !out_valid_q[k] || out_ready[k];
            end
        end
        in_ready = dest_ok ? tgt_free : 1'b1;
        wr_en    = in_valid && dest_ok && tgt_free;
        drop_en  = in_valid && !dest_ok;
    end

    // Per-channel register update: a write wins over a same-cycle drain, which
    // keeps each channel at one beat per cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (wr_en && (dest == SEL_W'(k))) begin
                out_valid_d[k]              = 1'b1;
                out_data_d[k*WIDTH +: WIDTH] = in_data;
            end else if (out_valid_q[k] && out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
    end

    // Round-robin pointer moves only on an accepted mode-1 beat, so a stalled
    // target holds the pointer and delivery stays in order.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (wr_en && mode) begin
            rr_ptr_d = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    // Saturating count of discarded out-of-range beats.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_en && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rr_ptr    = rr_ptr_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
